zap_fetch_queue: RTL and testbench

//  Parametrised fetch buffer between the I-cache and decode. Holds up to DEPTH fetched words

---
 rtl/zap_fetch_queue.sv | 130 +++++++++++++
 tb/tb_zap_fetch_queue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/zap_fetch_queue.sv
// Fetch buffer between I-cache and decode, with a flop-based 2-bit branch predictor.
// Head entry drives the outputs directly from storage; occupancy tracks full/empty.
module zap_fetch_queue #(
    parameter int DEPTH      = 4,
    parameter int BP_ENTRIES = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_flush,
    input  logic                       i_stall,
    input  logic                       i_valid,
    input  logic [31:0]                i_instruction,
    input  logic                       i_instr_abort,
    input  logic [31:0]                i_pc_ff,
    input  logic                       i_cpsr_ff_t,
    output logic                       o_ready,
    output logic                       o_valid,
    output logic [31:0]                o_instruction,
    output logic                       o_instr_abort,
    output logic [31:0]                o_pc_ff,
    output logic [31:0]                o_pc_plus_8_ff,
    output logic [1:0]                 o_taken_ff,
    output logic [$clog2(DEPTH):0]     o_count,
    input  logic                       i_confirm_from_alu,
    input  logic                       i_clear_from_alu,
    input  logic [31:0]                i_pc_from_alu,
    input  logic [1:0]                 i_taken
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int IDX = $clog2(BP_ENTRIES);

    logic [31:0] mem_instr [DEPTH];
    logic        mem_abort [DEPTH];
    logic [31:0] mem_pc    [DEPTH];
    logic [31:0] mem_pc8   [DEPTH];
    logic [1:0]  mem_taken [DEPTH];

    logic [1:0]  bp_table [BP_ENTRIES];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          sleep_ff;
    logic          full;
    logic          push;
    logic          pop;

    logic           bp_we;
    logic [IDX-1:0] bp_waddr;
    logic [1:0]     bp_wdata;
    logic [IDX-1:0] push_idx;
    logic [1:0]     push_taken;

    wire unused_pc_bits = &{1'b0, i_pc_from_alu[31:IDX+1], i_pc_from_alu[0]};

    assign full    = (count == CW'(DEPTH));
    assign o_ready = !full && !sleep_ff;
    assign o_valid = (count != '0);
    assign o_count = count;

    assign push = i_valid && o_ready && !i_flush;
    assign pop  = o_valid && !i_stall && !i_flush;

    assign bp_we    = !i_stall && (i_clear_from_alu || i_confirm_from_alu);
    assign bp_waddr = i_pc_from_alu[IDX:1];
    assign push_idx = i_pc_ff[IDX:1];

    // Mispredict nudges toward the opposite outcome; confirm saturates.
    always_comb begin
        bp_wdata = 2'b01;
        if (i_clear_from_alu) begin
            case (i_taken)
                2'b00:   bp_wdata = 2'b01;
                2'b01:   bp_wdata = 2'b10;
                2'b10:   bp_wdata = 2'b01;
                default: bp_wdata = 2'b10;
            endcase
        end else begin
            bp_wdata = i_taken[1] ? 2'b11 : 2'b00;
        end
    end

    // A same-cycle update to the fetched index is forwarded into the queued entry.
    assign push_taken = (bp_we && (bp_waddr == push_idx)) ? bp_wdata : bp_table[push_idx];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < BP_ENTRIES; i++) bp_table[i] <= 2'b01;
        end else if (bp_we) begin
            bp_table[bp_waddr] <= bp_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= i_instr_abort ? 32'd0 : i_instruction;
            mem_abort[wr_ptr] <= i_instr_abort;
            mem_pc[wr_ptr]    <= i_pc_ff;
            mem_pc8[wr_ptr]   <= i_pc_ff + (i_cpsr_ff_t ? 32'd4 : 32'd8);
            mem_taken[wr_ptr] <= push_taken;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            sleep_ff <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && i_instr_abort) sleep_ff <= 1'b1;
        end
    end

    assign o_instruction  = mem_instr[rd_ptr];
    assign o_instr_abort  = o_valid && mem_abort[rd_ptr];
    assign o_pc_ff        = mem_pc[rd_ptr];
    assign o_pc_plus_8_ff = mem_pc8[rd_ptr];
    assign o_taken_ff     = mem_taken[rd_ptr];

endmodule

// File: tb/tb_zap_fetch_queue.sv
// Scoreboard bench for zap_fetch_queue: a transaction-level model queues expected entries,
// a negedge monitor compares the head and occupancy against it.
module tb_zap_fetch_queue;

    localparam int DEPTH = 4;
    localparam int BPN   = 1024;

    logic        i_clk = 1'b0;
    logic        i_reset, i_flush, i_stall, i_valid, i_instr_abort, i_cpsr_ff_t;
    logic [31:0] i_instruction, i_pc_ff, i_pc_from_alu;
    logic        i_confirm_from_alu, i_clear_from_alu;
    logic [1:0]  i_taken;
    logic        o_ready, o_valid, o_instr_abort;
    logic [31:0] o_instruction, o_pc_ff, o_pc_plus_8_ff;
    logic [1:0]  o_taken_ff;
    logic [2:0]  o_count;

    zap_fetch_queue #(.DEPTH(DEPTH), .BP_ENTRIES(BPN)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_stall(i_stall),
        .i_valid(i_valid), .i_instruction(i_instruction), .i_instr_abort(i_instr_abort),
        .i_pc_ff(i_pc_ff), .i_cpsr_ff_t(i_cpsr_ff_t), .o_ready(o_ready), .o_valid(o_valid),
        .o_instruction(o_instruction), .o_instr_abort(o_instr_abort), .o_pc_ff(o_pc_ff),
        .o_pc_plus_8_ff(o_pc_plus_8_ff), .o_taken_ff(o_taken_ff), .o_count(o_count),
        .i_confirm_from_alu(i_confirm_from_alu), .i_clear_from_alu(i_clear_from_alu),
        .i_pc_from_alu(i_pc_from_alu), .i_taken(i_taken)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] instr;
        logic        abort;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [1:0]  taken;
    } ent_t;

    ent_t sb[$];
    int   m_count;
    bit   m_sleep;
    int   m_bp [BPN];
    int   misp_map [4] = '{1, 2, 1, 2};
    int   conf_map [4] = '{0, 0, 3, 3};
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: acts on the inputs presented at each rising edge.
    initial begin
        ent_t e;
        int   widx;
        bit   push, pop;
        m_count = 0;
        m_sleep = 0;
        forever begin
            @(posedge i_clk);
            if (i_reset) begin
                m_count = 0;
                m_sleep = 0;
                sb.delete();
                for (int i = 0; i < BPN; i++) m_bp[i] = 1;
            end else begin
                if (!i_stall && (i_clear_from_alu || i_confirm_from_alu)) begin
                    widx = int'((i_pc_from_alu >> 1) % BPN);
                    m_bp[widx] = i_clear_from_alu ? misp_map[i_taken] : conf_map[i_taken];
                end
                if (i_flush) begin
                    m_count = 0;
                    m_sleep = 0;
                    sb.delete();
                end else begin
                    push = i_valid && (m_count < DEPTH) && !m_sleep;
                    pop  = (m_count > 0) && !i_stall;
                    if (push) begin
                        e.instr = i_instr_abort ? 32'd0 : i_instruction;
                        e.abort = i_instr_abort;
                        e.pc    = i_pc_ff;
                        e.pc8   = i_pc_ff + (i_cpsr_ff_t ? 32'd4 : 32'd8);
                        e.taken = 2'(m_bp[int'((i_pc_ff >> 1) % BPN)]);
                        sb.push_back(e);
                        if (i_instr_abort) m_sleep = 1;
                    end
                    m_count = m_count + int'(push) - int'(pop);
                end
            end
        end
    end

    // Monitor: compares the presented head and occupancy, retires entries on pop.
    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_reset) begin
                chk("count", 32'(o_count), 32'(m_count));
                chk("valid", 32'(o_valid), 32'(m_count > 0));
                chk("ready", 32'(o_ready), 32'((m_count < DEPTH) && !m_sleep));
                chk("abort_idle", 32'(o_instr_abort && !o_valid), 32'd0);
                if (o_valid) begin
                    if (sb.size() == 0) begin
                        chk("head_expected", 32'd0, 32'd1);
                    end else begin
                        chk("head_instr", o_instruction, sb[0].instr);
                        chk("head_abort", 32'(o_instr_abort), 32'(sb[0].abort));
                        chk("head_pc", o_pc_ff, sb[0].pc);
                        chk("head_pc8", o_pc_plus_8_ff, sb[0].pc8);
                        chk("head_taken", 32'(o_taken_ff), 32'(sb[0].taken));
                        if (!i_stall && !i_flush) void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic idle();
        i_flush = 0; i_stall = 0; i_valid = 0; i_instr_abort = 0; i_cpsr_ff_t = 0;
        i_confirm_from_alu = 0; i_clear_from_alu = 0; i_taken = 2'b00;
    endtask

    task automatic push_word(input logic [31:0] pc, input logic abort);
        i_valid = 1; i_pc_ff = pc; i_instr_abort = abort;
        i_instruction = $urandom | 32'h1;
        step();
        i_valid = 0; i_instr_abort = 0;
    endtask

    task automatic alu_upd(input logic [31:0] pc, input bit clr, input logic [1:0] tk);
        i_pc_from_alu = pc; i_clear_from_alu = clr; i_confirm_from_alu = !clr; i_taken = tk;
        step();
        i_clear_from_alu = 0; i_confirm_from_alu = 0;
    endtask

    initial begin
        idle();
        i_instruction = 0; i_pc_ff = 0; i_pc_from_alu = 0;
        i_reset = 1;
        step(2);
        i_reset = 0;
        step();

        // T1: single push, Thumb off
        i_stall = 1;
        i_valid = 1; i_instruction = 32'hE1A00000; i_pc_ff = 32'h100;
        step();
        i_valid = 0;
        step();
        i_stall = 0;
        step(2);

        // T2: fill under stall, then drain across pointer wrap
        i_stall = 1;
        for (int k = 0; k <= DEPTH; k++) push_word(32'h300 + 32'(k * 4), 1'b0);
        i_stall = 0;
        step(DEPTH + 1);

        // T3: abort behind two words puts the queue to sleep
        i_stall = 1;
        push_word(32'h500, 1'b0);
        push_word(32'h504, 1'b0);
        push_word(32'h200, 1'b1);
        push_word(32'h508, 1'b0);
        i_stall = 0;
        step(4);
        i_flush = 1; step(); i_flush = 0;
        step();

        // T4: confirm, mispredict, stalled update on index 0x20
        alu_upd(32'h40, 1'b0, 2'b10);
        push_word(32'h40, 1'b0);
        alu_upd(32'h40, 1'b1, 2'b11);
        push_word(32'h40, 1'b0);
        i_stall = 1; alu_upd(32'h40, 1'b0, 2'b00); i_stall = 0;
        push_word(32'h40, 1'b0);
        step(2);

        // T5: forwarding of a same-cycle update into the pushed entry
        i_pc_from_alu = 32'h80; i_clear_from_alu = 1; i_taken = 2'b01;
        push_word(32'h80, 1'b0);
        i_clear_from_alu = 0;
        step(2);

        // T6: push+pop at count 2, then flush during a push
        i_stall = 1;
        push_word(32'h600, 1'b0);
        push_word(32'h604, 1'b0);
        i_stall = 0;
        push_word(32'h608, 1'b0);
        push_word(32'h60C, 1'b0);
        i_valid = 1; i_flush = 1; i_pc_ff = 32'h610;
        step();
        idle();
        step(2);

        // Randomised traffic, small PC range so predictor indices collide
        for (int c = 0; c < 3000; c++) begin
            i_valid       = ($urandom_range(0, 3) != 0);
            i_stall       = ($urandom_range(0, 3) == 0);
            i_flush       = ($urandom_range(0, 24) == 0);
            i_instr_abort = ($urandom_range(0, 15) == 0);
            i_cpsr_ff_t   = 1'($urandom);
            i_instruction = $urandom;
            i_pc_ff       = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : 32'($urandom_range(0, 63) * 2);
            i_pc_from_alu = 32'($urandom_range(0, 63) * 2);
            i_clear_from_alu   = ($urandom_range(0, 4) == 0);
            i_confirm_from_alu = ($urandom_range(0, 3) == 0);
            i_taken            = 2'($urandom);
            step();
        end
        idle();
        step(DEPTH + 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
